div: RTL

Multi-cycle 32-bit integer divider. It is the responder side of the EX-stage divide handshake. EX drives operands, sign mode and `start`, and holds the pipeline stalled until this block pulses `success` with a 64-bit `{remainder, quotient}` result. It uses a radix-2 restoring algorithm: one quotient bit per cycle, signed operation via magnitude conversion.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_if.sv | 26 ++
 rtl/div.sv | 131 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the multi-cycle integer divider.
//   DIV_WIDTH        default operand width
//   div_state_e      divider FSM states
//   DIV_RESULT_READY value of success_o when a result is presented
//   DIV_START        value of start_i that requests a divide
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_ZERO = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    localparam logic DIV_RESULT_READY = 1'b1;
    localparam logic DIV_START        = 1'b1;

endpackage

// File: rtl/div_if.sv
// div_if: EX-stage divide handshake.
//   master (EX)  : drives signed_i, dividend_i, divider_i, start_i, annul_i
//   slave  (div) : drives result_o {remainder, quotient} and success_o
interface div_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic                 signed_i;
    logic [WIDTH-1:0]     dividend_i;
    logic [WIDTH-1:0]     divider_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 success_o;

    modport master (
        output signed_i, dividend_i, divider_i, start_i, annul_i,
        input  result_o, success_o
    );

    modport slave (
        input  signed_i, dividend_i, divider_i, start_i, annul_i,
        output result_o, success_o
    );
endinterface

// File: rtl/div.sv
// div: radix-2 restoring divider, one quotient bit per cycle.
// Signed operands are converted to magnitudes at accept and the result
// signs are restored when the final iteration completes.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : div_if slave (operands/start/annul in, result/success out)
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_e         state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dsr_q, dsr_d;      // divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               success_q, success_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     shift_rem;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quot_nxt;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quot_fix;

    // One restoring step; the shifted remainder needs WIDTH+1 bits for the trial subtract
    always_comb begin
        shift_rem = {rem_q, dvd_q[WIDTH-1]};
        trial     = shift_rem - {1'b0, dsr_q};
        q_bit     = ~trial[WIDTH];
        rem_nxt   = q_bit ? trial[WIDTH-1:0] : shift_rem[WIDTH-1:0];
        quot_nxt  = {dvd_q[WIDTH-2:0], q_bit};
        rem_fix   = r_neg_q ? (WIDTH'(0) - rem_nxt)  : rem_nxt;
        quot_fix  = q_neg_q ? (WIDTH'(0) - quot_nxt) : quot_nxt;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        success_d = 1'b0;
        result_d  = '0;

        unique case (state_q)
            DIV_IDLE: begin
                if (bus.start_i == DIV_START) begin
                    if (bus.divider_i == '0) begin
                        // Divide by zero reports a fixed zero result
                        state_d   = DIV_ZERO;
                        success_d = DIV_RESULT_READY;
                    end else begin
                        state_d = DIV_BUSY;
                        dvd_d   = (bus.signed_i && bus.dividend_i[WIDTH-1])
                                  ? (WIDTH'(0) - bus.dividend_i) : bus.dividend_i;
                        dsr_d   = (bus.signed_i && bus.divider_i[WIDTH-1])
                                  ? (WIDTH'(0) - bus.divider_i) : bus.divider_i;
                        q_neg_d = bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divider_i[WIDTH-1]);
                        r_neg_d = bus.signed_i & bus.dividend_i[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            DIV_BUSY: begin
                dvd_d = quot_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last iteration: present the sign-corrected result in DONE
                    state_d   = DIV_DONE;
                    success_d = DIV_RESULT_READY;
                    result_d  = {rem_fix, quot_fix};
                end
            end
            DIV_ZERO: state_d = DIV_IDLE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        // Flush wins over everything, including a result about to be presented
        if (bus.annul_i) begin
            state_d   = DIV_IDLE;
            success_d = 1'b0;
            result_d  = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            success_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            success_q <= success_d;
            result_q  <= result_d;
        end
    end

    assign bus.success_o = success_q;
    assign bus.result_o  = result_q;

endmodule
